// File: rtl/counter_checker_pkg.sv
// Shared constants for counter_checker: FSM encodings, control-bit positions, log entry sizing.
// Latency: n/a (constants only).  Backpressure: n/a.
package counter_checker_pkg;

  localparam logic [1:0] ST_ARM    = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Bit positions inside the registered {syn_clr, load, en, up} control sample
  localparam int CTRL_UP      = 0;
  localparam int CTRL_EN      = 1;
  localparam int CTRL_LOAD    = 2;
  localparam int CTRL_SYN_CLR = 3;
  localparam int CTRL_W       = 4;

  // Log entry is {exp, got, max_err, min_err}
  function automatic int log_entry_w(input int n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/counter_checker_log_fifo.sv
// Generic synchronous FIFO, first-word-fall-through read port, sync clear.
// Latency: a push is visible on pop_dat/empty the cycle after the write edge.
// Backpressure: none; pushes while full and pops while empty are ignored (caller watches full/empty).
module counter_checker_log_fifo #(
  parameter int W   = 8,
  parameter int DEP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEP);

  logic [W-1:0] mem [DEP];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Step-checker for universal_binary_counter: compares q/ticks against the golden next-state rule.
// Latency: 1 clk from observed cycle to mismatch/counts; first compare 2 clks after reset or chk_clr.
// Backpressure: none; optional mismatch log (COUNTER_CHECKER_LOG_EN) drops entries when full and sets log_ovf.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int N       = 3,
  parameter int CW      = 16,
  parameter int HALT    = 0,
  parameter int LOG_DEP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          chk_clr,
  input  logic          syn_clr,
  input  logic          load,
  input  logic          en,
  input  logic          up,
  input  logic [N-1:0]  d,
  input  logic [N-1:0]  q,
  input  logic          max_tick,
  input  logic          min_tick,
  output logic          mismatch,
  output logic          err_sticky,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] chk_count,
  output logic [N-1:0]  first_exp,
  output logic [N-1:0]  first_got,
  output logic          halted
`ifdef COUNTER_CHECKER_LOG_EN
  ,
  input  logic                      log_rd,
  output logic                      log_empty,
  output logic [log_entry_w(N)-1:0] log_data,
  output logic                      log_ovf
`endif
);

  localparam logic [N-1:0]  Q_MAX   = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]        state;
  logic [N-1:0]      p_q;
  logic [N-1:0]      p_d;
  logic [CTRL_W-1:0] p_ctrl;
  logic [N-1:0]      exp_q;
  logic              q_err;
  logic              max_err;
  logic              min_err;
  logic              err;
  logic              do_cmp;

  // Previous-cycle sample of what drove the counter; sampled regardless of state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      p_d    <= '0;
      p_ctrl <= '0;
    end else begin
      p_q    <= q;
      p_d    <= d;
      p_ctrl <= {syn_clr, load, en, up};
    end
  end

  always_comb begin
    exp_q = p_q;
    if (p_ctrl[CTRL_SYN_CLR]) begin
      exp_q = '0;
    end else if (p_ctrl[CTRL_LOAD]) begin
      exp_q = p_d;
    end else if (p_ctrl[CTRL_EN]) begin
      exp_q = p_ctrl[CTRL_UP] ? p_q + N'(1) : p_q - N'(1);
    end
  end

  // Ticks are a pure function of the present q, not of the count direction
  assign max_err = max_tick != (q == Q_MAX);
  assign min_err = min_tick != (q == '0);
  assign q_err   = q != exp_q;
  assign err     = q_err || max_err || min_err;
  assign do_cmp  = (state == ST_CHECK) && !chk_clr;
  assign halted  = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARM;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      chk_count  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else if (chk_clr) begin
      state      <= ST_ARM;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      chk_count  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else begin
      case (state)
        ST_ARM: begin
          state    <= ST_CHECK;
          mismatch <= 1'b0;
        end
        ST_CHECK: begin
          mismatch <= err;
          if (chk_count != CNT_MAX) chk_count <= chk_count + CW'(1);
          if (err) begin
            if (err_count != CNT_MAX) err_count <= err_count + CW'(1);
            if (!err_sticky) begin
              err_sticky <= 1'b1;
              first_exp  <= exp_q;
              first_got  <= q;
            end
            if (HALT != 0) state <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          mismatch <= 1'b0;
        end
        default: begin
          state    <= ST_ARM;
          mismatch <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_CHECKER_LOG_EN
  logic log_push;
  logic log_full;

  assign log_push = do_cmp && err;

  counter_checker_log_fifo #(
    .W   (log_entry_w(N)),
    .DEP (LOG_DEP)
  ) u_log_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (chk_clr),
    .push     (log_push),
    .push_dat ({exp_q, q, max_err, min_err}),
    .pop      (log_rd),
    .pop_dat  (log_data),
    .empty    (log_empty),
    .full     (log_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_ovf <= 1'b0;
    end else if (chk_clr) begin
      log_ovf <= 1'b0;
    end else if (log_push && log_full) begin
      log_ovf <= 1'b1;
    end
  end
`else
  // Log depth only matters when the log is built in
  logic unused_log_dep;
  assign unused_log_dep = (LOG_DEP == 0) && do_cmp;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker (N=3, CW=16): counter stimulus with injected faults, scoreboarded mismatch pulses.
// Log tests are compiled in when COUNTER_CHECKER_LOG_EN is defined.
module tb_counter_checker;

  logic        clk;
  logic        rst_n;
  logic        chk_clr;
  logic        syn_clr;
  logic        load;
  logic        en;
  logic        up;
  logic [2:0]  d;
  logic [2:0]  q;
  logic        max_tick;
  logic        min_tick;

  logic        mismatch,   h_mismatch;
  logic        err_sticky, h_err_sticky;
  logic [15:0] err_count,  h_err_count;
  logic [15:0] chk_count,  h_chk_count;
  logic [2:0]  first_exp,  h_first_exp;
  logic [2:0]  first_got,  h_first_got;
  logic        halted,     h_halted;

`ifdef COUNTER_CHECKER_LOG_EN
  logic        log_rd;
  logic        log_empty, h_log_empty;
  logic [7:0]  log_data,  h_log_data;
  logic        log_ovf,   h_log_ovf;
  logic [7:0]  log_q[$];
  bit          m_ovf;
`endif

  int          checks;
  int          errors;

  // Bench-side counter model and expected checker state
  logic [2:0]  cnt;
  bit          armed;
  bit          sb_q[$];
  bit          sb_e;

  counter_checker #(.N(3), .CW(16), .HALT(0), .LOG_DEP(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .chk_clr(chk_clr), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick), .mismatch(mismatch), .err_sticky(err_sticky),
    .err_count(err_count), .chk_count(chk_count), .first_exp(first_exp), .first_got(first_got), .halted(halted)
`ifdef COUNTER_CHECKER_LOG_EN
    , .log_rd(log_rd), .log_empty(log_empty), .log_data(log_data), .log_ovf(log_ovf)
`endif
  );

  counter_checker #(.N(3), .CW(16), .HALT(1), .LOG_DEP(4)) u_halt (
    .clk(clk), .rst_n(rst_n), .chk_clr(chk_clr), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q), .max_tick(max_tick), .min_tick(min_tick), .mismatch(h_mismatch), .err_sticky(h_err_sticky),
    .err_count(h_err_count), .chk_count(h_chk_count), .first_exp(h_first_exp), .first_got(h_first_got),
    .halted(h_halted)
`ifdef COUNTER_CHECKER_LOG_EN
    , .log_rd(log_rd), .log_empty(h_log_empty), .log_data(h_log_data), .log_ovf(h_log_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Scoreboard: one expected mismatch bit per driven cycle, compared after the edge that registers it
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_e = sb_q.pop_front();
      checks++;
      if (mismatch !== sb_e) begin
        errors++;
        $display("FAIL sb_mismatch at %0t: got %b expected %b", $time, mismatch, sb_e);
      end
    end
  end

  // Drive one counter cycle. fq replaces q by qv (the counter glitches and continues from qv);
  // fmt/fmn invert the max/min tick outputs.
  task automatic step(input bit sc, input bit ld, input bit e, input bit u, input logic [2:0] dd,
                      input bit fq, input logic [2:0] qv, input bit fmt, input bit fmn, input bit clr);
    logic [2:0] qp;
    bit         bad;
    bit         cmp;
    qp       = fq ? qv : cnt;
    syn_clr  = sc;
    load     = ld;
    en       = e;
    up       = u;
    d        = dd;
    q        = qp;
    max_tick = (qp == 3'd7) ^ fmt;
    min_tick = (qp == 3'd0) ^ fmn;
    chk_clr  = clr;
    bad      = (qp != cnt) || fmt || fmn;
    cmp      = armed && !clr;
    sb_q.push_back(cmp && bad);
`ifdef COUNTER_CHECKER_LOG_EN
    if (clr) begin
      log_q.delete();
      m_ovf = 1'b0;
    end else if (cmp && bad) begin
      if (log_q.size() < 4) log_q.push_back({cnt, qp, fmt, fmn});
      else m_ovf = 1'b1;
    end
`endif
    armed = !clr;
    if (sc)     cnt = 3'd0;
    else if (ld) cnt = dd;
    else if (e)  cnt = u ? qp + 3'd1 : qp - 3'd1;
    else         cnt = qp;
    @(posedge clk);
    #2;
    chk_clr = 1'b0;
  endtask

  task automatic run(input bit e, input bit u, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, e, u, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({mismatch, err_sticky, err_count, chk_count, first_exp, first_got, halted} !== '0) begin
      errors++;
      $display("FAIL reset_dut: got %b/%b/%h/%h/%h/%h/%b expected all zero", mismatch, err_sticky,
               err_count, chk_count, first_exp, first_got, halted);
    end
    checks++;
    if ({h_mismatch, h_err_sticky, h_err_count, h_chk_count, h_first_exp, h_first_got, h_halted} !== '0) begin
      errors++;
      $display("FAIL reset_halt: got %b/%b/%h/%h/%b expected all zero", h_mismatch, h_err_sticky,
               h_err_count, h_chk_count, h_halted);
    end
`ifdef COUNTER_CHECKER_LOG_EN
    checks++;
    if (log_empty !== 1'b1 || log_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_log: empty=%b ovf=%b expected empty=1 ovf=0", log_empty, log_ovf);
    end
    log_q.delete();
    m_ovf = 1'b0;
`endif
    cnt   = 3'd0;
    armed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_up_count();
    run(1'b1, 1'b1, 20);
    checks++;
    if (chk_count !== 16'd19 || err_count !== 16'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL up_count: chk=%0d err=%0d sticky=%b expected chk=19 err=0 sticky=0",
               chk_count, err_count, err_sticky);
    end
  endtask

  task automatic test_down_force();
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    run(1'b1, 1'b0, 2);
    checks++;
    if (first_exp !== 3'd3 || first_got !== 3'd6) begin
      errors++;
      $display("FAIL down_first: exp=%0d got=%0d expected exp=3 got=6", first_exp, first_got);
    end
    checks++;
    if (err_count !== 16'd1 || chk_count !== 16'd4 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL down_counts: err=%0d chk=%0d sticky=%b expected err=1 chk=4 sticky=1",
               err_count, chk_count, err_sticky);
    end
    // Second fault via min_tick must count but leave the first-error capture alone
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err_count !== 16'd2 || first_exp !== 3'd3 || first_got !== 3'd6) begin
      errors++;
      $display("FAIL down_second: err=%0d exp=%0d got=%0d expected err=2 exp=3 got=6",
               err_count, first_exp, first_got);
    end
  endtask

  task automatic test_clr_load();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mismatch !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_load_q0: mismatch=%b err=%0d expected 0/0", mismatch, err_count);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mismatch !== 1'b1 || first_got !== 3'd6 || first_exp !== 3'd0) begin
      errors++;
      $display("FAIL clr_load_q6: mismatch=%b exp=%0d got=%0d expected 1/0/6", mismatch, first_exp, first_got);
    end
  endtask

  task automatic test_halt();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    run(1'b1, 1'b1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, cnt ^ 3'b100, 1'b0, 1'b0, 1'b0);
    checks++;
    if (h_mismatch !== 1'b1 || h_halted !== 1'b1 || h_err_count !== 16'd1) begin
      errors++;
      $display("FAIL halt_first: mismatch=%b halted=%b err=%0d expected 1/1/1", h_mismatch, h_halted, h_err_count);
    end
    run(1'b1, 1'b1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, cnt ^ 3'b010, 1'b0, 1'b0, 1'b0);
    checks++;
    if (h_mismatch !== 1'b0 || h_halted !== 1'b1 || h_err_count !== 16'd1 || h_chk_count !== 16'd3) begin
      errors++;
      $display("FAIL halt_hold: mismatch=%b halted=%b err=%0d chk=%0d expected 0/1/1/3",
               h_mismatch, h_halted, h_err_count, h_chk_count);
    end
    checks++;
    if (err_count !== 16'd2 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_nohalt: err=%0d halted=%b expected 2/0", err_count, halted);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (h_halted !== 1'b0 || h_err_count !== 16'd0 || h_chk_count !== 16'd0 || h_err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL halt_clr: halted=%b err=%0d chk=%0d sticky=%b expected all 0",
               h_halted, h_err_count, h_chk_count, h_err_sticky);
    end
    run(1'b1, 1'b1, 4);
    checks++;
    if (h_chk_count !== 16'd3 || h_halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_resume: chk=%0d halted=%b expected 3/0", h_chk_count, h_halted);
    end
  endtask

  task automatic test_clr_wins();
    run(1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, cnt ^ 3'b001, 1'b1, 1'b0, 1'b1);
    checks++;
    if (err_count !== 16'd0 || chk_count !== 16'd0 || err_sticky !== 1'b0 || first_got !== 3'd0) begin
      errors++;
      $display("FAIL clr_wins: err=%0d chk=%0d sticky=%b got=%0d expected all 0",
               err_count, chk_count, err_sticky, first_got);
    end
  endtask

  task automatic test_reset_mid();
    run(1'b1, 1'b1, 3);
    test_reset();
    run(1'b1, 1'b1, 1);
    checks++;
    if (chk_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_arm: chk=%0d expected 0", chk_count);
    end
    run(1'b1, 1'b1, 1);
    checks++;
    if (chk_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_first: chk=%0d expected 1", chk_count);
    end
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1);
    for (int i = 0; i < 65534; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 16'hFFFE || chk_count !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_pre: err=%h chk=%h expected fffe/fffe", err_count, chk_count);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (err_count !== 16'hFFFF || chk_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: err=%h chk=%h expected ffff/ffff", err_count, chk_count);
    end
  endtask

`ifdef COUNTER_CHECKER_LOG_EN
  task automatic test_log();
    logic [7:0] want;
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    run(1'b0, 1'b0, 1);
    for (int i = 2; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (log_ovf !== 1'b1 || log_empty !== 1'b0 || m_ovf !== 1'b1 || log_q.size() != 4) begin
      errors++;
      $display("FAIL log_fill: ovf=%b empty=%b expected ovf=1 empty=0 with 4 entries", log_ovf, log_empty);
    end
    for (int i = 0; i < 4; i++) begin
      want = log_q.pop_front();
      checks++;
      if (log_data !== want) begin
        errors++;
        $display("FAIL log_entry%0d: got %h expected %h", i, log_data, want);
      end
      log_rd = 1'b1;
      run(1'b0, 1'b0, 1);
      log_rd = 1'b0;
    end
    checks++;
    if (log_empty !== 1'b1) begin
      errors++;
      $display("FAIL log_drain: empty=%b expected 1", log_empty);
    end
    log_rd = 1'b1;
    run(1'b0, 1'b0, 1);
    log_rd = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, cnt ^ 3'b011, 1'b0, 1'b0, 1'b0);
    want = log_q.pop_front();
    checks++;
    if (log_empty !== 1'b0 || log_data !== want) begin
      errors++;
      $display("FAIL log_after_empty_rd: empty=%b data=%h expected 0/%h", log_empty, log_data, want);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (log_empty !== 1'b1 || log_ovf !== 1'b0) begin
      errors++;
      $display("FAIL log_clr: empty=%b ovf=%b expected 1/0", log_empty, log_ovf);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    errors   = 0;
    chk_clr  = 1'b0;
    syn_clr  = 1'b0;
    load     = 1'b0;
    en       = 1'b0;
    up       = 1'b0;
    d        = 3'd0;
    q        = 3'd0;
    max_tick = 1'b0;
    min_tick = 1'b1;
    cnt      = 3'd0;
    armed    = 1'b0;
`ifdef COUNTER_CHECKER_LOG_EN
    log_rd   = 1'b0;
    m_ovf    = 1'b0;
`endif
    test_reset();
    test_up_count();
    test_down_force();
    test_clr_load();
    test_halt();
    test_clr_wins();
    test_reset_mid();
`ifdef COUNTER_CHECKER_LOG_EN
    test_log();
`endif
    test_saturate();
    @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
